// File: rtl/output_layer_accumulator.sv
// Output-layer MAC stage: ten parallel signed dot products over a stream
// of hidden activations, saturated and held for softMax under valid/ready.

`ifndef SOFTMAX_IN_BIT_WIDTH
`define SOFTMAX_IN_BIT_WIDTH 16
`endif

module output_layer_accumulator #(
  parameter int IN_WIDTH     = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int NUM_INPUTS   = 64,
  parameter int ACC_WIDTH    = 24,
  parameter int SUM_WIDTH    = `SOFTMAX_IN_BIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          activation,
  input  logic [10*WEIGHT_WIDTH-1:0]   weights,
  output logic [10*SUM_WIDTH-1:0]      sum_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int NC = 10;
  localparam int PW = IN_WIDTH + WEIGHT_WIDTH;
  localparam int CW = $clog2(NUM_INPUTS + 1);

  localparam logic signed [ACC_WIDTH-1:0] MAXV =
    {{(ACC_WIDTH-SUM_WIDTH+1){1'b0}}, {(SUM_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV =
    {{(ACC_WIDTH-SUM_WIDTH+1){1'b1}}, {(SUM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUT
  } state_t;

  state_t                       r_state;
  state_t                       w_next_state;
  logic signed [ACC_WIDTH-1:0]  r_acc [NC];
  logic signed [ACC_WIDTH-1:0]  w_acc_next [NC];
  logic [CW-1:0]                r_count;
  logic [10*SUM_WIDTH-1:0]      r_sum;
  logic [10*SUM_WIDTH-1:0]      w_sat;
  logic                         w_last;

  // Clamp a wide accumulator into the signed output range.
  function automatic logic [SUM_WIDTH-1:0] sat(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (v > MAXV)
      return MAXV[SUM_WIDTH-1:0];
    else if (v < MINV)
      return MINV[SUM_WIDTH-1:0];
    else
      return v[SUM_WIDTH-1:0];
  endfunction

  // Per-class product, sign-extended sum, and saturated packed result.
  always_comb begin
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] prod;
    w_sat = '0;
    a_ext = {{WEIGHT_WIDTH{activation[IN_WIDTH-1]}}, activation};
    for (int k = 0; k < NC; k++) begin
      w_ext = {{IN_WIDTH{weights[(10-k)*WEIGHT_WIDTH-1]}},
               weights[(10-k)*WEIGHT_WIDTH-1 -: WEIGHT_WIDTH]};
      prod  = a_ext * w_ext;
      w_acc_next[k] = r_acc[k] +
        {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
      w_sat[(10-k)*SUM_WIDTH-1 -: SUM_WIDTH] = sat(w_acc_next[k]);
    end
  end

  assign w_last = (r_count == CW'(NUM_INPUTS - 1));

  // Next-state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_next_state = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, accumulators, beat counter and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_sum   <= '0;
      for (int k = 0; k < NC; k++) r_acc[k] <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && start) begin
        r_count <= '0;
        for (int k = 0; k < NC; k++) r_acc[k] <= '0;
      end else if (in_ready && in_valid) begin
        r_count <= r_count + CW'(1);
        for (int k = 0; k < NC; k++) r_acc[k] <= w_acc_next[k];
        if (w_last) r_sum <= w_sat;
      end
    end
  end

  assign sum_out = r_sum;

endmodule
